// File: rtl/adder_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_arbiter_pkg
//  Purpose  : Shared helpers for the adder_arbiter block: word-length and
//             index-width derivation plus the round-robin pointer wrap.
//  Revision : 1.0  initial release
// ============================================================================
package adder_arbiter_pkg;

  // Larger of two word lengths; the exact sum needs one bit more than this.
  function automatic int max_f(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Ceiling log2 for small positive values (index width of a requester id).
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Next round-robin start position after index idx was served.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
//  Module   : adder_arbiter_rr_grant
//  Purpose  : rr_grant block. Purely combinational round-robin selector:
//             finds the first asserted valid bit searching upward from ptr_i,
//             wrapping modulo N_REQ. Returns one-hot grant, its index and an
//             "any" flag.
//  Revision : 1.0  initial release
// ============================================================================
module adder_arbiter_rr_grant
  import adder_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  // Candidate index examined at search offset k, folded back into range.
  function automatic int cand_idx(input int p, input int k);
    int s;
    s = p + k;
    return (s >= N_REQ) ? s - N_REQ : s;
  endfunction

  logic [ID_W-1:0] w_cand;

  // Walk the requesters from the pointer upward; the first valid one wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = ID_W'(cand_idx(int'(ptr_i), k));
      if (!any_o && valid_i[w_cand]) begin
        any_o           = 1'b1;
        idx_o           = w_cand;
        grant_o[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : adder_arbiter
//  Purpose  : N_REQ requesters each offer a signed operand pair (A, B). A
//             round-robin arbiter accepts one pair per cycle into an operand
//             register (stage 1); stage 2 holds the exact sign-extended sum
//             and the owner id behind a valid/ready result port.
//             Two-cycle latency, one result per cycle, full backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter  int WL_A   = 4,
  parameter  int WL_B   = 5,
  parameter  int N_REQ  = 4,
  localparam int WL_OUT = max_f(WL_A, WL_B) + 1,
  localparam int ID_W   = clog2_f(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*WL_A-1:0]   req_a_i,
  input  logic [N_REQ*WL_B-1:0]   req_b_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [WL_OUT-1:0]       res_sum_o,
  output logic [ID_W-1:0]         res_id_o
);

  localparam int C_EXT_A = WL_OUT - WL_A;
  localparam int C_EXT_B = WL_OUT - WL_B;

  // Arbitration
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_grant_idx;
  logic              w_grant_any;

  // Stage 1: operand register
  logic              s1_valid_q, s1_valid_d;
  logic [WL_A-1:0]   s1_a_q, s1_a_d;
  logic [WL_B-1:0]   s1_b_q, s1_b_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;

  // Stage 2: result register
  logic              res_valid_q, res_valid_d;
  logic [WL_OUT-1:0] res_sum_q, res_sum_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;

  // Pipeline control and datapath wires
  logic              w_s1_adv;
  logic              w_s1_room;
  logic              w_accept;
  logic [WL_A-1:0]   w_sel_a;
  logic [WL_B-1:0]   w_sel_b;
  logic [WL_OUT-1:0] w_ext_a;
  logic [WL_OUT-1:0] w_ext_b;
  logic [WL_OUT-1:0] w_sum;

  adder_arbiter_rr_grant #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_grant (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (w_grant),
    .idx_o   (w_grant_idx),
    .any_o   (w_grant_any)
  );

  // Stage 1 moves forward when the result slot is free or being drained;
  // it can take a new pair when empty or moving forward this same cycle.
  // Reset blocks the handshake so nothing is accepted while it is asserted.
  always_comb begin
    w_s1_adv    = s1_valid_q && (!res_valid_q || res_ready_i);
    w_s1_room   = !s1_valid_q || w_s1_adv;
    w_accept    = w_grant_any && w_s1_room && !rst_i;
    req_ready_o = w_accept ? w_grant : '0;
  end

  // Route the granted requester's operands to stage 1.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_idx == ID_W'(i)) begin
        w_sel_a = req_a_i[i*WL_A +: WL_A];
        w_sel_b = req_b_i[i*WL_B +: WL_B];
      end
    end
  end

  // Exact sum: both operands sign-extended to the result width, so the
  // addition can never overflow.
  always_comb begin
    w_ext_a = {{C_EXT_A{s1_a_q[WL_A-1]}}, s1_a_q};
    w_ext_b = {{C_EXT_B{s1_b_q[WL_B-1]}}, s1_b_q};
    w_sum   = w_ext_a + w_ext_b;
  end

  // Round-robin pointer moves past the winner only on a real acceptance.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_accept) begin
      rr_ptr_d = ID_W'(wrap_inc(int'(w_grant_idx), N_REQ));
    end
  end

  // Stage 1 next state: load on acceptance, empty when it hands off.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    if (w_accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = w_sel_a;
      s1_b_d     = w_sel_b;
      s1_id_d    = w_grant_idx;
    end else if (w_s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state: load from stage 1, otherwise drop valid once the
  // consumer takes the result; held unchanged while stalled.
  always_comb begin
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    if (w_s1_adv) begin
      res_valid_d = 1'b1;
      res_sum_d   = w_sum;
      res_id_d    = s1_id_q;
    end else if (res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  // Pipeline and pointer registers; reset clears everything in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_sum_o   = res_sum_q;
  assign res_id_o    = res_id_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_arbiter
//  Purpose  : Self-checking bench for adder_arbiter (WL_A=4, WL_B=5, N_REQ=4).
//             A transaction-level model (two slots, integer sums) predicts
//             ready/valid/sum/id every cycle; directed scenarios add literal
//             expectations on grants, sums and timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_arbiter;

  localparam int WL_A   = 4;
  localparam int WL_B   = 5;
  localparam int N_REQ  = 4;
  localparam int WL_OUT = 6;
  localparam int ID_W   = 2;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic [N_REQ-1:0]      req_valid_i;
  logic [N_REQ-1:0]      req_ready_o;
  logic [N_REQ*WL_A-1:0] req_a_i;
  logic [N_REQ*WL_B-1:0] req_b_i;
  logic                  res_valid_o;
  logic                  res_ready_i;
  logic [WL_OUT-1:0]     res_sum_o;
  logic [ID_W-1:0]       res_id_o;

  adder_arbiter #(
    .WL_A  (WL_A),
    .WL_B  (WL_B),
    .N_REQ (N_REQ)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_sum_o   (res_sum_o),
    .res_id_o    (res_id_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Observed handshakes (actuals), with the edge number they complete on.
  int acc_id[$];
  int acc_e[$];
  int res_s[$];
  int res_i[$];
  int res_e[$];

  // Model: slot 1 = accepted operands, slot 2 = visible result.
  bit m1_v = 0, m2_v = 0, n1_v = 0, n2_v = 0;
  int m1_sum = 0, m1_id = 0, m2_sum = 0, m2_id = 0, m_ptr = 0;
  int n1_sum = 0, n1_id = 0, n2_sum = 0, n2_id = 0, n_ptr = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sx(input int v, input int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    int ta, tb;
    ta = int'(req_a_i);
    tb = int'(req_b_i);
    ta = (ta & ~(((1 << WL_A) - 1) << (i * WL_A))) | ((a & ((1 << WL_A) - 1)) << (i * WL_A));
    tb = (tb & ~(((1 << WL_B) - 1) << (i * WL_B))) | ((b & ((1 << WL_B) - 1)) << (i * WL_B));
    req_a_i = ta[N_REQ*WL_A-1:0];
    req_b_i = tb[N_REQ*WL_B-1:0];
  endtask

  // Compare process: mid-cycle check of DUT outputs against the model,
  // then prepare the model's next state and log observed handshakes.
  always @(negedge clk_i) begin
    int  g, vb, e_r, a_v, b_v;
    bit  adv, room, acc;
    if (rst_i) begin
      m1_v = 0; m2_v = 0; m1_sum = 0; m1_id = 0; m2_sum = 0; m2_id = 0; m_ptr = 0;
      n1_v = 0; n2_v = 0; n1_sum = 0; n1_id = 0; n2_sum = 0; n2_id = 0; n_ptr = 0;
      chk("rst_req_ready", int'(req_ready_o), 0);
      chk("rst_res_valid", int'(res_valid_o), 0);
      chk("rst_res_sum", int'(res_sum_o), 0);
      chk("rst_res_id", int'(res_id_o), 0);
    end else begin
      adv  = m1_v && (!m2_v || res_ready_i);
      room = !m1_v || adv;
      vb   = int'(req_valid_i);
      g    = -1;
      for (int k = 0; k < N_REQ; k++) begin
        if (g < 0 && (((vb >> ((m_ptr + k) % N_REQ)) & 1) == 1)) g = (m_ptr + k) % N_REQ;
      end
      acc = (g >= 0) && room;
      e_r = acc ? (1 << g) : 0;
      chk("req_ready", int'(req_ready_o), e_r);
      chk("res_valid", int'(res_valid_o), int'(m2_v));
      if (m2_v) begin
        chk("res_sum", int'($signed(res_sum_o)), m2_sum);
        chk("res_id", int'(res_id_o), m2_id);
      end
      n2_v = m2_v; n2_sum = m2_sum; n2_id = m2_id;
      if (adv) begin
        n2_v = 1; n2_sum = m1_sum; n2_id = m1_id;
      end else if (m2_v && res_ready_i) begin
        n2_v = 0;
      end
      n1_v = m1_v; n1_sum = m1_sum; n1_id = m1_id; n_ptr = m_ptr;
      if (acc) begin
        a_v    = (int'(req_a_i) >> (g * WL_A)) & ((1 << WL_A) - 1);
        b_v    = (int'(req_b_i) >> (g * WL_B)) & ((1 << WL_B) - 1);
        n1_v   = 1;
        n1_sum = sx(a_v, WL_A) + sx(b_v, WL_B);
        n1_id  = g;
        n_ptr  = (g + 1) % N_REQ;
      end else if (adv) begin
        n1_v = 0;
      end
      for (int k = 0; k < N_REQ; k++) begin
        if (((int'(req_ready_o & req_valid_i) >> k) & 1) == 1) begin
          acc_id.push_back(k);
          acc_e.push_back(cyc + 1);
        end
      end
      if (res_valid_o && res_ready_i) begin
        res_s.push_back(int'($signed(res_sum_o)));
        res_i.push_back(int'(res_id_o));
        res_e.push_back(cyc + 1);
      end
    end
  end

  // Commit the model state on the active edge.
  always @(posedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      m1_v = n1_v; m1_sum = n1_sum; m1_id = n1_id;
      m2_v = n2_v; m2_sum = n2_sum; m2_id = n2_id;
      m_ptr = n_ptr;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int na, nr;
    req_valid_i = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    res_ready_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    step();
    chk("init_res_valid", int'(res_valid_o), 0);
    chk("init_res_sum", int'(res_sum_o), 0);
    chk("init_res_id", int'(res_id_o), 0);
    chk("init_req_ready", int'(req_ready_o), 0);

    // Single request from requester 0: 2 + (-15) = -13, two cycles later.
    na = acc_id.size(); nr = res_s.size();
    set_req(0, 4'b0010, 5'b10001);
    req_valid_i = 4'b0001;
    step();
    req_valid_i = '0;
    repeat (3) step();
    chk("A_acc_id", acc_id[na], 0);
    chk("A_sum", res_s[nr], -13);
    chk("A_id", res_i[nr], 0);
    chk("A_latency", res_e[nr] - acc_e[na], 2);

    // Requester 2 back-to-back: -1 + -1 = -2, then -8 + -11 = -19.
    na = acc_id.size(); nr = res_s.size();
    set_req(2, 4'b1111, 5'b11111);
    req_valid_i = 4'b0100;
    step();
    set_req(2, 4'b1000, 5'b10101);
    step();
    req_valid_i = '0;
    repeat (3) step();
    chk("B_acc_id0", acc_id[na], 2);
    chk("B_acc_id1", acc_id[na+1], 2);
    chk("B_sum0", res_s[nr], -2);
    chk("B_sum1", res_s[nr+1], -19);
    chk("B_id1", res_i[nr+1], 2);
    chk("B_consecutive", res_e[nr+1] - res_e[nr], 1);

    // Extremes: most negative (-8 + -16 = -24) and most positive (7 + 15 = 22).
    na = acc_id.size(); nr = res_s.size();
    set_req(1, 4'b1000, 5'b10000);
    set_req(3, 4'b0111, 5'b01111);
    req_valid_i = 4'b0010;
    step();
    req_valid_i = 4'b1000;
    step();
    req_valid_i = '0;
    repeat (3) step();
    chk("C_sum_min", res_s[nr], -24);
    chk("C_id_min", res_i[nr], 1);
    chk("C_sum_max", res_s[nr+1], 22);
    chk("C_id_max", res_i[nr+1], 3);

    // All four requesting for 8 cycles: grants rotate 0,1,2,3,0,1,2,3.
    na = acc_id.size();
    for (int i = 0; i < N_REQ; i++) set_req(i, i + 1, 3 * i);
    req_valid_i = 4'b1111;
    repeat (8) step();
    req_valid_i = '0;
    repeat (3) step();
    chk("D_acc_count", acc_id.size() - na, 8);
    for (int k = 0; k < 8; k++) chk("D_grant_order", acc_id[na+k], k % 4);
    chk("D_one_per_cycle", acc_e[na+7] - acc_e[na], 7);

    // Backpressure for 5 cycles with continuous requests.
    na = acc_id.size(); nr = res_s.size();
    res_ready_i = 1'b0;
    set_req(0, 4'b0011, 5'b00100);
    set_req(1, 4'b0101, 5'b11110);
    set_req(2, 4'b0001, 5'b00001);
    set_req(3, 4'b1110, 5'b00001);
    req_valid_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k >= 1) begin
        chk("E_hold_valid", int'(res_valid_o), 1);
        chk("E_hold_sum", int'($signed(res_sum_o)), 7);
        chk("E_hold_id", int'(res_id_o), 0);
      end
    end
    chk("E_stall_accepts", acc_id.size() - na, 2);
    // Requester 2 holds the grant, then withdraws before acceptance.
    req_valid_i = 4'b0100;
    step();
    req_valid_i = '0;
    step();
    // Release: drain, advance and accept in the same cycle.
    req_valid_i = 4'b1100;
    res_ready_i = 1'b1;
    step();
    req_valid_i = '0;
    for (int k = 0; k < 20 && (res_s.size() - nr) < 3; k++) step();
    repeat (2) step();
    chk("E_results", res_s.size() - nr, 3);
    chk("E_after_drop_grant", acc_id[na+2], 2);
    chk("E_sum0", res_s[nr], 7);
    chk("E_sum1", res_s[nr+1], 3);
    chk("E_sum2", res_s[nr+2], 2);
    chk("E_id2", res_i[nr+2], 2);
    chk("E_no_bubble", res_e[nr+2] - res_e[nr], 2);

    // Reset with both stages occupied.
    res_ready_i = 1'b0;
    set_req(0, 4'b0100, 5'b00011);
    set_req(1, 4'b0110, 5'b00110);
    req_valid_i = 4'b0001;
    step();
    req_valid_i = 4'b0010;
    step();
    req_valid_i = '0;
    step();
    chk("F_pre_res_valid", int'(res_valid_o), 1);
    rst_i = 1'b1;
    #1;
    chk("F_rst_immediate", int'(res_valid_o), 0);
    set_req(0, 4'b0001, 5'b00001);
    req_valid_i = 4'b1111;
    res_ready_i = 1'b1;
    #1;
    chk("F_rst_no_ready", int'(req_ready_o), 0);
    step();
    step();
    na = acc_id.size(); nr = res_s.size();
    rst_i = 1'b0;
    step();
    req_valid_i = '0;
    repeat (4) step();
    chk("F_acc_count", acc_id.size() - na, 1);
    chk("F_first_grant", acc_id[na], 0);
    chk("F_res_count", res_s.size() - nr, 1);
    chk("F_sum", res_s[nr], 2);
    chk("F_id", res_i[nr], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
